aes128_enc_iter: RTL



---
 rtl/aes128_enc_iter_pkg.sv | 91 +++++++++
 rtl/aes128_enc_iter_round_step.sv | 30 +++
 rtl/aes128_enc_iter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES-128 definitions for the iterative encryption core: FSM encoding,
// S-box and RCON lookups, MixColumns helpers and the key-schedule step.
package aes128_enc_iter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

   localparam int unsigned NUM_ROUNDS = 10;

   // S-box entry b lives at bits [8*(255-b) +: 8], i.e. entry 0 is the MSB byte
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column is {row0, row1, row2, row3}, row0 in the MSB byte
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Derives round key rnd from round key rnd-1
   function automatic logic [127:0] key_step(input logic [127:0] key, input logic [3:0] rnd);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = key[127:96];
      w1 = key[95:64];
      w2 = key[63:32];
      w3 = key[31:0];
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes128_enc_iter_round_step.sv
// One AES encryption round (SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey); purely combinational so several can be chained per clock.
module aes_round_step
   import aes128_enc_iter_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         final_i,
   output logic [127:0] state_o
);

   logic [127:0] sr;
   logic [127:0] mc;

   // Byte k of the state is at [127-8k -: 8]; row = k%4, column = k/4
   always_comb begin
      sr = '0;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127 - 8*(4*c + r) -: 8] = sbox(state_i[127 - 8*(4*((c + r) % 4) + r) -: 8]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
      end
      state_o = (final_i ? sr : mc) ^ round_key_i;
   end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE chained rounds per clock with
// on-the-fly key expansion, optional CBC chaining, valid/ready on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no block held; in_ready=1
//   ST_RUN  | applying rounds; inputs ignored
//   ST_DONE | ciphertext on out_block, out_valid=1 until out_ready
module aes128_enc_iter
   import aes128_enc_iter_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit CBC_EN           = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] in_key,
   input  logic         in_first,
   input  logic [127:0] iv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block
);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
       ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
      $error("aes128_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
   end

   localparam logic [3:0] RPC        = 4'(ROUNDS_PER_CYCLE);
   localparam logic [3:0] LAST_START = 4'(NUM_ROUNDS + 1 - ROUNDS_PER_CYCLE);

   fsm_e         fsm_q, fsm_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] chain_q, chain_d;
   logic [127:0] out_block_q, out_block_d;
   logic         out_valid_q, out_valid_d;

   logic         accept;
   logic [127:0] chain_sel;
   logic [127:0] st_last;
   logic [127:0] key_last;

   for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
      logic [127:0] st_in, key_in, st_out, key_out;
      logic [3:0]   rnd;
      if (g == 0) begin : g_first
         assign st_in  = blk_q;
         assign key_in = key_q;
      end else begin : g_next
         assign st_in  = g_round[g-1].st_out;
         assign key_in = g_round[g-1].key_out;
      end
      assign rnd     = round_q + 4'(g);
      assign key_out = key_step(key_in, rnd);
      aes_round_step u_step (
         .state_i     (st_in),
         .round_key_i (key_out),
         .final_i     (rnd == 4'(NUM_ROUNDS)),
         .state_o     (st_out)
      );
   end

   assign st_last   = g_round[ROUNDS_PER_CYCLE-1].st_out;
   assign key_last  = g_round[ROUNDS_PER_CYCLE-1].key_out;

   // out_ready feeds in_ready directly so DONE can hand over to a new block in one edge
   assign in_ready  = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign chain_sel = CBC_EN ? (in_first ? iv : chain_q) : '0;
   assign out_valid = out_valid_q;
   assign out_block = out_block_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q       <= ST_IDLE;
         blk_q       <= '0;
         key_q       <= '0;
         round_q     <= '0;
         chain_q     <= '0;
         out_block_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         blk_q       <= blk_d;
         key_q       <= key_d;
         round_q     <= round_d;
         chain_q     <= chain_d;
         out_block_q <= out_block_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      blk_d       = blk_q;
      key_d       = key_q;
      round_d     = round_q;
      chain_d     = chain_q;
      out_block_d = out_block_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         ST_IDLE: ;
         ST_RUN: begin
            blk_d   = st_last;
            key_d   = key_last;
            round_d = round_q + RPC;
            if (round_q == LAST_START) begin
               fsm_d       = ST_DONE;
               round_d     = '0;
               out_block_d = st_last;
               out_valid_d = 1'b1;
               if (CBC_EN) chain_d = st_last;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
      // Accept overrides the IDLE/DONE defaults above
      if (accept) begin
         blk_d   = (in_block ^ chain_sel) ^ in_key;
         key_d   = in_key;
         round_d = 4'd1;
         fsm_d   = ST_RUN;
      end
   end

endmodule
